// File: rtl/mem_bus_pkg.sv
// ============================================================================
// mem_bus_pkg : state encoding and bus constants shared by memory-bus initiators
// Revision    : 1.0
// ============================================================================
`default_nettype none

package mem_bus_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_REQ = 3'd1,
    RD_GAP = 3'd2,
    WR_REQ = 3'd3,
    WR_GAP = 3'd4,
    DONE   = 3'd5
  } state_t;

  localparam logic MEM_READ  = 1'b1;
  localparam logic MEM_WRITE = 1'b0;

  function automatic logic is_bus_state(input state_t s);
    return (s == RD_REQ) || (s == RD_GAP) || (s == WR_REQ) || (s == WR_GAP);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_bus_timeout.sv
// ============================================================================
// mem_bus_timeout : loadable down-counter with clear, enable and expired flag
// Revision        : 1.0
// ============================================================================
`default_nettype none

module mem_bus_timeout #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             enable,
  output logic             expired
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_value;
    end else if (enable && (r_count != '0)) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  // Flags the last permitted waiting cycle, so the caller aborts on the edge
  // that closes wait cycle number load_value.
  assign expired = (r_count == CNT_W'(1));

endmodule

`default_nettype wire

// File: rtl/mem_copy_master.sv
// ============================================================================
// mem_copy_master : DMA-style block copy initiator for the CPU memory bus
// Revision        : 1.0
// ============================================================================
`default_nettype none

module mem_copy_master
  import mem_bus_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int LEN_BITS = 8,
  parameter int TIMEOUT  = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [WIDTH-1:0]    src_addr,
  input  logic [WIDTH-1:0]    dst_addr,
  input  logic [LEN_BITS-1:0] length,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [WIDTH-1:0]    mem_address,
  output logic                mem_nwr,
  output logic [WIDTH-1:0]    mem_data_out,
  input  logic [WIDTH-1:0]    mem_data_in,
  output logic                mem_valid,
  input  logic                mem_ready
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t              r_state;
  state_t              w_next_state;
  logic                w_abort;
  logic [WIDTH-1:0]    r_src_ptr;
  logic [WIDTH-1:0]    r_dst_ptr;
  logic [LEN_BITS-1:0] r_remaining;
  logic [WIDTH-1:0]    r_hold;
  logic                r_error;
  logic                w_expired;
  logic                w_timer_load;
  logic                w_timer_enable;
  logic                w_timer_clear;

  // Every transition into a REQ/GAP state changes state, so a state change
  // identifies entry and restarts the wait budget.
  assign w_timer_load   = is_bus_state(w_next_state) && (w_next_state != r_state);
  assign w_timer_enable = is_bus_state(r_state) && !w_timer_load;
  assign w_timer_clear  = !is_bus_state(r_state) && !w_timer_load;

  mem_bus_timeout #(
    .CNT_W (CNT_W)
  ) u_timeout (
    .clk        (clk),
    .reset      (reset),
    .clear      (w_timer_clear),
    .load       (w_timer_load),
    .load_value (CNT_W'(TIMEOUT)),
    .enable     (w_timer_enable),
    .expired    (w_expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_abort      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next_state = (length == '0) ? DONE : RD_REQ;
        end
      end
      RD_REQ: begin
        if (mem_ready) begin
          w_next_state = RD_GAP;
        end else if (w_expired) begin
          w_next_state = DONE;
          w_abort      = 1'b1;
        end
      end
      RD_GAP: begin
        if (!mem_ready) begin
          w_next_state = WR_REQ;
        end else if (w_expired) begin
          w_next_state = DONE;
          w_abort      = 1'b1;
        end
      end
      WR_REQ: begin
        if (mem_ready) begin
          w_next_state = WR_GAP;
        end else if (w_expired) begin
          w_next_state = DONE;
          w_abort      = 1'b1;
        end
      end
      WR_GAP: begin
        if (!mem_ready) begin
          w_next_state = (r_remaining == '0) ? DONE : RD_REQ;
        end else if (w_expired) begin
          w_next_state = DONE;
          w_abort      = 1'b1;
        end
      end
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    busy         = 1'b0;
    done         = 1'b0;
    mem_valid    = 1'b0;
    mem_nwr      = MEM_READ;
    mem_address  = '0;
    mem_data_out = '0;
    case (r_state)
      RD_REQ: begin
        busy        = 1'b1;
        mem_valid   = 1'b1;
        mem_address = r_src_ptr;
      end
      RD_GAP, WR_GAP: busy = 1'b1;
      WR_REQ: begin
        busy         = 1'b1;
        mem_valid    = 1'b1;
        mem_nwr      = MEM_WRITE;
        mem_address  = r_dst_ptr;
        mem_data_out = r_hold;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_src_ptr   <= '0;
      r_dst_ptr   <= '0;
      r_remaining <= '0;
      r_hold      <= '0;
      r_error     <= 1'b0;
    end else begin
      if ((r_state == IDLE) && start) begin
        r_src_ptr   <= src_addr;
        r_dst_ptr   <= dst_addr;
        r_remaining <= length;
        r_error     <= 1'b0;
      end
      if ((r_state == RD_REQ) && mem_ready) begin
        r_hold    <= mem_data_in;
        r_src_ptr <= r_src_ptr + WIDTH'(1);
      end
      if ((r_state == WR_REQ) && mem_ready) begin
        r_dst_ptr   <= r_dst_ptr + WIDTH'(1);
        r_remaining <= r_remaining - LEN_BITS'(1);
      end
      if (w_abort) begin
        r_error <= 1'b1;
      end
    end
  end

  assign error = r_error;

endmodule

`default_nettype wire
